linha_envase_param: RTL

LINHA_ENVASE_PARAM -- requirements
Module: linha_envase_param

---
 rtl/envase_pkg.sv | 29 ++
 rtl/estoque_param.sv | 78 +++++++
 rtl/linha_envase_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/envase_pkg.sv
// ----------------------------------------------------------------------------
// envase_pkg
// Shared definitions for the bottling line: default parameter values and the
// FSM state encoding. The encoding is also driven out on o_state, so
// monitoring tools depend on these values. Do not reorder them.
// ----------------------------------------------------------------------------
package envase_pkg;

    // Default parameter values for the line and the stopper magazine
    localparam int PACK_SIZE_DEF    = 12;
    localparam int PACK_MAX_DEF     = 10;
    localparam int CNT_W_DEF        = 8;
    localparam int LINE_CAP_DEF     = 5;
    localparam int LOW_STOCK_DEF    = 5;
    localparam int FILL_TIMEOUT_DEF = 64;

    // FSM states; the 4-bit value is the externally visible o_state code
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADVANCE = 4'd1,
        ST_FILL    = 4'd2,
        ST_SEAL    = 4'd3,
        ST_INSPECT = 4'd4,
        ST_DISCARD = 4'd5,
        ST_COUNT   = 4'd6,
        ST_HALT    = 4'd7
    } state_t;

endpackage

// File: rtl/estoque_param.sv
// ----------------------------------------------------------------------------
// estoque_param
// Stopper stock and line magazine. The dispenser moves one stopper per cycle
// from stock into the line magazine while there is room and stock. It pauses
// during the sealing cycle so that the line is never refilled and consumed in
// the same cycle. Refills add to stock and saturate at the counter maximum.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_add_stock         one-cycle refill pulse
//   i_stock_qty         number of stoppers added by the refill
//   i_ve                sealing valve active this cycle (consumes one stopper)
//   o_stock_count       stoppers in stock
//   o_line_count        stoppers in the line magazine
//   o_disp              a transfer from stock to line happens this cycle
//   o_alarme            stock below LOW_STOCK
// ----------------------------------------------------------------------------
module estoque_param
    import envase_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LINE_CAP  = LINE_CAP_DEF,
    parameter int LOW_STOCK = LOW_STOCK_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_add_stock,
    input  logic [CNT_W-1:0] i_stock_qty,
    input  logic             i_ve,
    output logic [CNT_W-1:0] o_stock_count,
    output logic [CNT_W-1:0] o_line_count,
    output logic             o_disp,
    output logic             o_alarme
);

    logic [CNT_W-1:0] r_stock;
    logic [CNT_W-1:0] r_line;
    logic             w_disp;
    logic [CNT_W:0]   w_stockSum;
    logic [CNT_W-1:0] w_stockNext;

    // A transfer needs room in the line and a stopper in stock. It is held off
    // while the valve is consuming from the line.
    assign w_disp = (r_line < CNT_W'(LINE_CAP)) && (r_stock != '0) && !i_ve;

    // The next stock value is computed one bit wider. The transfer is removed
    // first, then the refill is added. Any carry out saturates the count at
    // all ones.
    always_comb begin
        w_stockSum = {1'b0, r_stock} - {{CNT_W{1'b0}}, w_disp};
        if (i_add_stock) begin
            w_stockSum = w_stockSum + {1'b0, i_stock_qty};
        end
        w_stockNext = w_stockSum[CNT_W] ? '1 : w_stockSum[CNT_W-1:0];
    end

    // The stock and line registers. A transfer and a valve consumption never
    // coincide, and the guards keep the line within 0..LINE_CAP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stock <= '0;
            r_line  <= '0;
        end else begin
            r_stock <= w_stockNext;
            if (w_disp) begin
                r_line <= r_line + 1'b1;
            end else if (i_ve && (r_line != '0)) begin
                r_line <= r_line - 1'b1;
            end
        end
    end

    assign o_stock_count = r_stock;
    assign o_line_count  = r_line;
    assign o_disp        = w_disp;
    assign o_alarme      = (r_stock < CNT_W'(LOW_STOCK));

endmodule

// File: rtl/linha_envase_param.sv
// ----------------------------------------------------------------------------
// linha_envase_param
// Bottling line controller. Each bottle goes through the sequence
// advance -> fill -> seal -> inspect -> count/discard. Good bottles are
// counted into packs of PACK_SIZE, and the pack counter wraps after PACK_MAX
// packs. A fill that never reaches level locks the line in HALT until reset.
// All outputs are decoded from registered state and counters.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               run enable (level)
//   i_garrafa             bottle at fill position
//   i_sensor_nivel        fill level reached
//   i_cq_valid, i_cq_ok   QC result strobe and pass flag
//   i_add_stock           one-cycle stopper refill pulse
//   i_stock_qty           stoppers added by the refill
//   o_motor, o_ev, o_ve   conveyor motor, fill valve, sealing valve
//   o_disp                stopper transfer stock -> line this cycle
//   o_descarte            reject actuator
//   o_alarme              low stock
//   o_fault               fill timeout fault (HALT)
//   o_pack_done           pack counter wrap pulse
//   o_stock_count, o_line_count, o_unit_count, o_pack_count   counters
//   o_state               current state code
// ----------------------------------------------------------------------------
module linha_envase_param
    import envase_pkg::*;
#(
    parameter int PACK_SIZE    = PACK_SIZE_DEF,
    parameter int PACK_MAX     = PACK_MAX_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LINE_CAP     = LINE_CAP_DEF,
    parameter int LOW_STOCK    = LOW_STOCK_DEF,
    parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_garrafa,
    input  logic             i_sensor_nivel,
    input  logic             i_cq_valid,
    input  logic             i_cq_ok,
    input  logic             i_add_stock,
    input  logic [CNT_W-1:0] i_stock_qty,
    output logic             o_motor,
    output logic             o_ev,
    output logic             o_ve,
    output logic             o_disp,
    output logic             o_descarte,
    output logic             o_alarme,
    output logic             o_fault,
    output logic             o_pack_done,
    output logic [CNT_W-1:0] o_stock_count,
    output logic [CNT_W-1:0] o_line_count,
    output logic [CNT_W-1:0] o_unit_count,
    output logic [CNT_W-1:0] o_pack_count,
    output logic [3:0]       o_state
);

    localparam int FW = $clog2(FILL_TIMEOUT + 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [FW-1:0]    r_fillCnt;
    logic             r_inspEntry;
    logic [CNT_W-1:0] r_unitCount;
    logic [CNT_W-1:0] r_packCount;
    logic [CNT_W-1:0] w_lineCount;
    logic             w_ve;
    logic             w_unitWrap;
    logic             w_packWrap;
    logic             w_fillExpired;

    estoque_param #(
        .CNT_W     (CNT_W),
        .LINE_CAP  (LINE_CAP),
        .LOW_STOCK (LOW_STOCK)
    ) u_estoque (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_add_stock   (i_add_stock),
        .i_stock_qty   (i_stock_qty),
        .i_ve          (w_ve),
        .o_stock_count (o_stock_count),
        .o_line_count  (w_lineCount),
        .o_disp        (o_disp),
        .o_alarme      (o_alarme)
    );

    // The sealing valve fires only when a stopper is available. Otherwise the
    // bottle waits in SEAL until the dispenser delivers one.
    assign w_ve          = (r_state == ST_SEAL) && (w_lineCount != '0);
    assign w_unitWrap    = (r_unitCount == CNT_W'(PACK_SIZE - 1));
    assign w_packWrap    = (r_packCount == CNT_W'(PACK_MAX - 1));
    assign w_fillExpired = (r_fillCnt == FW'(FILL_TIMEOUT - 1));

    // Next-state logic. Dropping start abandons the bottle from any active
    // state. DISCARD and COUNT always take their single cycle, so their
    // counter update still lands. HALT is left only through reset.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_nextState = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (!i_start)       w_nextState = ST_IDLE;
                else if (i_garrafa) w_nextState = ST_FILL;
            end
            ST_FILL: begin
                if (!i_start)            w_nextState = ST_IDLE;
                else if (i_sensor_nivel) w_nextState = ST_SEAL;
                else if (w_fillExpired)  w_nextState = ST_HALT;
            end
            ST_SEAL: begin
                if (!i_start) w_nextState = ST_IDLE;
                else if (w_ve) w_nextState = ST_INSPECT;
            end
            ST_INSPECT: begin
                if (!i_start)        w_nextState = ST_IDLE;
                else if (i_cq_valid) w_nextState = i_cq_ok ? ST_COUNT : ST_DISCARD;
            end
            ST_DISCARD, ST_COUNT: begin
                w_nextState = i_start ? ST_ADVANCE : ST_IDLE;
            end
            ST_HALT: begin
                w_nextState = ST_HALT;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from the state register and registered counters.
    // The motor pulses on the first INSPECT cycle to move the sealed bottle
    // under the QC station.
    always_comb begin
        o_motor     = 1'b0;
        o_ev        = 1'b0;
        o_descarte  = 1'b0;
        o_fault     = 1'b0;
        o_pack_done = 1'b0;
        case (r_state)
            ST_ADVANCE: o_motor     = 1'b1;
            ST_FILL:    o_ev        = 1'b1;
            ST_INSPECT: o_motor     = r_inspEntry;
            ST_DISCARD: o_descarte  = 1'b1;
            ST_COUNT:   o_pack_done = w_unitWrap && w_packWrap;
            ST_HALT:    o_fault     = 1'b1;
            default:    o_motor     = 1'b0;
        endcase
    end

    // State, fill timer, INSPECT entry flag and unit/pack counters. The fill
    // timer runs only while in FILL and restarts from zero on every entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_fillCnt   <= '0;
            r_inspEntry <= 1'b0;
            r_unitCount <= '0;
            r_packCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_inspEntry <= (w_nextState == ST_INSPECT) && (r_state != ST_INSPECT);
            if (r_state == ST_FILL) begin
                r_fillCnt <= r_fillCnt + 1'b1;
            end else begin
                r_fillCnt <= '0;
            end
            if (r_state == ST_COUNT) begin
                if (w_unitWrap) begin
                    r_unitCount <= '0;
                    if (w_packWrap) begin
                        r_packCount <= '0;
                    end else begin
                        r_packCount <= r_packCount + 1'b1;
                    end
                end else begin
                    r_unitCount <= r_unitCount + 1'b1;
                end
            end
        end
    end

    assign o_ve         = w_ve;
    assign o_line_count = w_lineCount;
    assign o_unit_count = r_unitCount;
    assign o_pack_count = r_packCount;
    assign o_state      = r_state;

endmodule
